rapid_if_stage: RTL and testbench
=================================

Name: rapid_if_stage

Overview:
Instruction-fetch stage of the rapid pipeline. It owns the program counter and issues word reads to the instruction cache. It presents each fetched instruction and its PC to the decode stage over a valid/ready handshake. It accepts branch redirects from execute and a halt request. Its state machine uses the pipeline's IF states FETCH, WAIT, NEXT and HALT.

Parameters:
RESET_VECTOR, 0, PC value loaded on reset.
WORD_WIDTH, 4, PC increment in bytes per sequential fetch.
ADDR_W, 32, PC and address width.

Ports:
clk  in  1  pipeline clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
icache_req  out  1  read request to the instruction cache; high exactly while state==WAIT.
icache_addr  out  ADDR_W  fetch address; equals the current PC; low 2 bits always 0.
icache_op  out  2  cache_operation encoding: WORD (3) while icache_req=1, CACHE_NOP (0) otherwise.
icache_ack  in  1  cache has returned data this cycle; only meaningful when icache_req=1.
icache_rdata  in  32  instruction word; valid with icache_ack.
de_valid  out  1  instruction available to decode.
de_instr  out  32  instruction word; stable while de_valid=1.
de_pc  out  ADDR_W  PC of de_instr.
de_ready  in  1  decode accepts; handshake = de_valid & de_ready.
redirect_valid  in  1  one-cycle branch/jump redirect from execute.
redirect_pc  in  ADDR_W  redirect target; low 2 bits are forced to 0 on capture.
halt_req  in  1  request to stop fetching; sticky once sampled.
halted  out  1  high while state==HALT.

Behaviour:
- Reset: pc=RESET_VECTOR (low 2 bits cleared), state=FETCH.
  - Outputs: icache_req=0, icache_op=CACHE_NOP, de_valid=0, de_instr=0, de_pc=0, halted=0.
  - Internal flags: squash=0, halt_pend=0.
  - Reset has priority over every other input in the same cycle.
  - Reset mid-transaction abandons any outstanding request; a late icache_ack is ignored because state is FETCH.
- FETCH:
  - If halt_pend or halt_req: go to HALT.
  - Otherwise go to WAIT.
  - Takes one cycle with no request.
- WAIT:
  - icache_req=1, icache_addr=pc; pc is held stable for the whole request.
  - On icache_ack, with squash=0: de_instr<=icache_rdata, de_pc<=pc, de_valid<=1, go to NEXT.
  - On icache_ack, with squash=1: discard the data, clear squash, go to FETCH.
  - Same-cycle ack is allowed, giving a minimum request length of 1 cycle.
- NEXT:
  - de_valid=1; de_instr and de_pc are held until the handshake.
  - On handshake: pc<=pc+WORD_WIDTH, de_valid<=0, go to FETCH.
  - PC arithmetic is modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0x00000000.
- HALT:
  - No requests; halted=1.
  - redirect_valid and de_ready are ignored.
  - The only exit is reset.
- Redirect (redirect_valid=1):
  - In FETCH: pc<=redirect_pc; state proceeds as normal.
  - In WAIT: pc change is deferred until the cycle after ack so that icache_addr stays stable. The target is stored, squash<=1, and pc<=stored target when ack arrives.
    - Redirect in the same cycle as ack: the data is discarded and the stage goes to FETCH with pc=redirect_pc.
  - In NEXT: pc<=redirect_pc, de_valid<=0, go to FETCH. This applies even if a handshake occurs in the same cycle; redirect wins over the pc+4 update.
  - A second redirect while squash=1 overwrites the stored target.
- halt_req:
  - Sets halt_pend; takes effect at the next entry to FETCH.
  - An in-flight fetch completes and is delivered to decode first.
- Throughput: at most one instruction per 3 cycles (FETCH, WAIT, NEXT) with ack in 1 cycle and ready asserted.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, RESET_VECTOR=0x100; cache acks the first cycle of each request; de_ready=1.
  - Required: icache_addr sequence 0x100, 0x104, 0x108; de_valid pulses 3 cycles apart; first de_valid 2 cycles after reset deasserts; de_pc matches each address.
- Backpressure:
  - Stimulus: de_ready=0 for 5 cycles after de_valid rises.
  - Required: de_instr and de_pc held; no new icache_req; pc advances to 0x104 only on the cycle after de_ready=1.
- Redirect during WAIT:
  - Stimulus: cache delays ack 3 cycles; redirect_pc=0x2002 asserted in the 2nd WAIT cycle.
  - Required: icache_addr stays 0x100 until ack; data discarded with no de_valid; next request addr 0x2000.
- Redirect vs handshake:
  - Stimulus: in NEXT, de_ready=1 and redirect_valid=1 (redirect_pc=0x40) in the same cycle.
  - Required: next fetch addr 0x40, not pc+4.
- Halt:
  - Stimulus: halt_req pulsed during WAIT.
  - Required: current instruction delivered; then halted=1; icache_req stays 0 for 20 cycles despite redirects.
- Wrap and reset:
  - Stimulus: redirect to 0xFFFFFFFC and fetch twice; then assert reset mid-WAIT with a late ack.
  - Required: addrs 0xFFFFFFFC then 0x00000000; after reset de_valid=0, late ack ignored, first fetch at RESET_VECTOR.

Source files
------------

// File: rtl/rapid_if_stage.sv
// rapid_if_stage: instruction-fetch stage of the rapid pipeline.
// Owns the program counter, issues single-word reads to the instruction
// cache and hands each fetched instruction plus its PC to decode over a
// valid/ready handshake. Accepts branch redirects from execute and a sticky
// halt request.
//
// Ports:
//   clk            pipeline clock, rising edge
//   reset          synchronous active-high reset
//   icache_req     read request, high exactly while in WAIT
//   icache_addr    fetch address (current PC, word aligned)
//   icache_op      WORD (3) while requesting, CACHE_NOP (0) otherwise
//   icache_ack     cache returns data this cycle
//   icache_rdata   instruction word, valid with icache_ack
//   de_valid       instruction available to decode
//   de_instr       instruction word, held while de_valid
//   de_pc          PC of de_instr
//   de_ready       decode accepts
//   redirect_valid one-cycle redirect strobe from execute
//   redirect_pc    redirect target (low 2 bits dropped on capture)
//   halt_req       stop fetching after the in-flight instruction
//   halted         high while in HALT
module rapid_if_stage #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}},
    parameter int                WORD_WIDTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_addr,
    output logic [1:0]        icache_op,
    input  logic              icache_ack,
    input  logic [31:0]       icache_rdata,
    output logic              de_valid,
    output logic [31:0]       de_instr,
    output logic [ADDR_W-1:0] de_pc,
    input  logic              de_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_NEXT  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [1:0] OP_CACHE_NOP = 2'd0;
    localparam logic [1:0] OP_WORD      = 2'd3;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(WORD_WIDTH);

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    logic [1:0]        state_r,     state_s;
    logic [ADDR_W-1:0] pc_r,        pc_s;
    logic [ADDR_W-1:0] target_r,    target_s;
    logic              squash_r,    squash_s;
    logic              halt_pend_r, halt_pend_s;
    logic              de_valid_r,  de_valid_s;
    logic [31:0]       de_instr_r,  de_instr_s;
    logic [ADDR_W-1:0] de_pc_r,     de_pc_s;
    logic              req_r;
    logic [1:0]        op_r;
    logic              halted_r;

    // Next-state and datapath decisions for the fetch state machine.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        target_s    = target_r;
        squash_s    = squash_r;
        halt_pend_s = halt_pend_r | halt_req;
        de_valid_s  = de_valid_r;
        de_instr_s  = de_instr_r;
        de_pc_s     = de_pc_r;

        case (state_r)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_s = word_align(redirect_pc);
                end else begin
                    pc_s = pc_r;
                end
                if (halt_pend_r || halt_req) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // PC must stay on icache_addr until the ack, so a redirect is
                // parked in target_r and the returning data is dropped.
                if (redirect_valid) begin
                    target_s = word_align(redirect_pc);
                    squash_s = 1'b1;
                end else begin
                    target_s = target_r;
                end
                if (icache_ack) begin
                    if (squash_r || redirect_valid) begin
                        squash_s = 1'b0;
                        // A redirect arriving with the ack is the newest target.
                        if (redirect_valid) begin
                            pc_s = word_align(redirect_pc);
                        end else begin
                            pc_s = target_r;
                        end
                        state_s = ST_FETCH;
                    end else begin
                        de_instr_s = icache_rdata;
                        de_pc_s    = pc_r;
                        de_valid_s = 1'b1;
                        state_s    = ST_NEXT;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end

            ST_NEXT: begin
                // Redirect beats the sequential increment even on a handshake.
                if (redirect_valid) begin
                    pc_s       = word_align(redirect_pc);
                    de_valid_s = 1'b0;
                    state_s    = ST_FETCH;
                end else if (de_ready) begin
                    pc_s       = pc_r + PC_STEP;
                    de_valid_s = 1'b0;
                    state_s    = ST_FETCH;
                end else begin
                    state_s = ST_NEXT;
                end
            end

            ST_HALT: begin
                state_s = ST_HALT;
            end

            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // State, PC and decode-side registers; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_FETCH;
            pc_r        <= word_align(RESET_VECTOR);
            target_r    <= {ADDR_W{1'b0}};
            squash_r    <= 1'b0;
            halt_pend_r <= 1'b0;
            de_valid_r  <= 1'b0;
            de_instr_r  <= 32'd0;
            de_pc_r     <= {ADDR_W{1'b0}};
            req_r       <= 1'b0;
            op_r        <= OP_CACHE_NOP;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            target_r    <= target_s;
            squash_r    <= squash_s;
            halt_pend_r <= halt_pend_s;
            de_valid_r  <= de_valid_s;
            de_instr_r  <= de_instr_s;
            de_pc_r     <= de_pc_s;
            req_r       <= (state_s == ST_WAIT);
            op_r        <= (state_s == ST_WAIT) ? OP_WORD : OP_CACHE_NOP;
            halted_r    <= (state_s == ST_HALT);
        end
    end

    assign icache_req  = req_r;
    assign icache_addr = pc_r;
    assign icache_op   = op_r;
    assign de_valid    = de_valid_r;
    assign de_instr    = de_instr_r;
    assign de_pc       = de_pc_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_rapid_if_stage.sv
// Directed self-checking bench for rapid_if_stage (RESET_VECTOR = 0x100).
module tb_rapid_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic [1:0]  icache_op;
    logic        icache_ack;
    logic [31:0] icache_rdata;
    logic        de_valid;
    logic [31:0] de_instr;
    logic [31:0] de_pc;
    logic        de_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int dv_cyc0;
    int dv_cyc1;

    rapid_if_stage #(
        .ADDR_W       (32),
        .RESET_VECTOR (32'h0000_0100),
        .WORD_WIDTH   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_op      (icache_op),
        .icache_ack     (icache_ack),
        .icache_rdata   (icache_rdata),
        .de_valid       (de_valid),
        .de_instr       (de_instr),
        .de_pc          (de_pc),
        .de_ready       (de_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        reset          = 1'b1;
        icache_ack     = 1'b0;
        icache_rdata   = 32'd0;
        de_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt_req       = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_req",      {31'd0, icache_req}, 32'd0);
        check("rst_op",       {30'd0, icache_op},  32'd0);
        check("rst_de_valid", {31'd0, de_valid},   32'd0);
        check("rst_de_instr", de_instr,            32'd0);
        check("rst_de_pc",    de_pc,               32'd0);
        check("rst_halted",   {31'd0, halted},     32'd0);
        check("rst_addr",     icache_addr,         32'h0000_0100);
        reset = 1'b0;

        // ---------------- sequential fetch ----------------
        step();                                   // WAIT 0x100
        check("seq0_req",  {31'd0, icache_req}, 32'd1);
        check("seq0_op",   {30'd0, icache_op},  32'd3);
        check("seq0_addr", icache_addr,         32'h0000_0100);
        icache_ack = 1'b1; icache_rdata = 32'hA000_0001;
        step();                                   // NEXT, 2 cycles after reset release
        icache_ack = 1'b0;
        check("seq0_dv",    {31'd0, de_valid},  32'd1);
        check("seq0_pc",    de_pc,              32'h0000_0100);
        check("seq0_instr", de_instr,           32'hA000_0001);
        check("seq0_noreq", {31'd0, icache_req}, 32'd0);
        dv_cyc0 = cyc;
        step();                                   // FETCH
        check("seq1_fetch_dv", {31'd0, de_valid}, 32'd0);
        step();                                   // WAIT 0x104
        check("seq1_addr", icache_addr, 32'h0000_0104);
        icache_ack = 1'b1; icache_rdata = 32'hA000_0002;
        step();
        icache_ack = 1'b0;
        dv_cyc1 = cyc;
        check("seq1_dv",      {31'd0, de_valid}, 32'd1);
        check("seq1_pc",      de_pc,             32'h0000_0104);
        check("seq_spacing",  dv_cyc1 - dv_cyc0, 32'd3);
        step();                                   // FETCH
        step();                                   // WAIT 0x108
        check("seq2_addr", icache_addr, 32'h0000_0108);
        de_ready   = 1'b0;
        icache_ack = 1'b1; icache_rdata = 32'hA000_0003;
        step();
        icache_ack = 1'b0;
        check("seq2_dv", {31'd0, de_valid}, 32'd1);
        check("seq2_pc", de_pc,             32'h0000_0108);

        // ---------------- backpressure ----------------
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_dv",    {31'd0, de_valid},   32'd1);
            check("bp_instr", de_instr,            32'hA000_0003);
            check("bp_pc",    de_pc,               32'h0000_0108);
            check("bp_noreq", {31'd0, icache_req}, 32'd0);
            check("bp_addr",  icache_addr,         32'h0000_0108);
        end
        de_ready = 1'b1;
        step();                                   // FETCH, pc advanced
        check("bp_rel_dv",   {31'd0, de_valid}, 32'd0);
        check("bp_rel_addr", icache_addr,       32'h0000_010C);

        // ---------------- redirect during WAIT ----------------
        step();                                   // WAIT cycle 1
        check("rw_w1_req",  {31'd0, icache_req}, 32'd1);
        check("rw_w1_addr", icache_addr,         32'h0000_010C);
        step();                                   // WAIT cycle 2
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
        step();                                   // WAIT cycle 3
        redirect_valid = 1'b0;
        check("rw_w3_req",  {31'd0, icache_req}, 32'd1);
        check("rw_w3_addr", icache_addr,         32'h0000_010C);
        step();                                   // WAIT cycle 4, ack now
        check("rw_w4_addr", icache_addr,         32'h0000_010C);
        icache_ack = 1'b1; icache_rdata = 32'hDEAD_BEEF;
        step();                                   // FETCH, data dropped
        icache_ack = 1'b0;
        check("rw_drop_dv", {31'd0, de_valid},   32'd0);
        check("rw_fetch_req", {31'd0, icache_req}, 32'd0);
        step();                                   // WAIT 0x2000
        check("rw_new_req",  {31'd0, icache_req}, 32'd1);
        check("rw_new_addr", icache_addr,        32'h0000_2000);
        check("rw_still_no_dv", {31'd0, de_valid}, 32'd0);
        icache_ack = 1'b1; icache_rdata = 32'hA000_2000;
        step();                                   // NEXT
        icache_ack = 1'b0;
        check("rw_dv",    {31'd0, de_valid}, 32'd1);
        check("rw_pc",    de_pc,             32'h0000_2000);
        check("rw_instr", de_instr,          32'hA000_2000);

        // ---------------- redirect vs handshake ----------------
        de_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        step();                                   // FETCH
        redirect_valid = 1'b0;
        check("rh_dv", {31'd0, de_valid}, 32'd0);
        step();                                   // WAIT 0x40
        check("rh_req",  {31'd0, icache_req}, 32'd1);
        check("rh_addr", icache_addr,         32'h0000_0040);

        // ---------------- halt ----------------
        halt_req = 1'b1;
        step();                                   // still WAIT
        halt_req = 1'b0;
        check("h_wait_req",  {31'd0, icache_req}, 32'd1);
        check("h_not_yet",   {31'd0, halted},     32'd0);
        icache_ack = 1'b1; icache_rdata = 32'hA000_0040;
        step();                                   // NEXT, delivered
        icache_ack = 1'b0;
        check("h_dv",    {31'd0, de_valid}, 32'd1);
        check("h_pc",    de_pc,             32'h0000_0040);
        check("h_instr", de_instr,          32'hA000_0040);
        step();                                   // FETCH
        check("h_fetch_halted", {31'd0, halted}, 32'd0);
        step();                                   // HALT
        check("h_halted", {31'd0, halted},     32'd1);
        check("h_noreq",  {31'd0, icache_req}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            redirect_valid = i[0];
            redirect_pc    = 32'h0000_3000 + 32'(i * 4);
            step();
            check("h_hold_req",    {31'd0, icache_req}, 32'd0);
            check("h_hold_halted", {31'd0, halted},     32'd1);
            check("h_hold_op",     {30'd0, icache_op},  32'd0);
        end
        redirect_valid = 1'b0;

        // ---------------- wrap and reset ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("wr_rst_halted", {31'd0, halted}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();                                   // WAIT 0xFFFFFFFC
        redirect_valid = 1'b0;
        check("wr_addr0", icache_addr, 32'hFFFF_FFFC);
        icache_ack = 1'b1; icache_rdata = 32'hA0FF_FFFC;
        step();
        icache_ack = 1'b0;
        check("wr_pc0", de_pc, 32'hFFFF_FFFC);
        step();                                   // FETCH
        step();                                   // WAIT 0x0
        check("wr_req1",  {31'd0, icache_req}, 32'd1);
        check("wr_addr1", icache_addr,         32'h0000_0000);
        reset = 1'b1;
        step();                                   // reset mid-WAIT
        reset = 1'b0;
        check("wr_rst_dv",   {31'd0, de_valid},   32'd0);
        check("wr_rst_req",  {31'd0, icache_req}, 32'd0);
        check("wr_rst_addr", icache_addr,         32'h0000_0100);
        icache_ack = 1'b1; icache_rdata = 32'hBAD0_BAD0;   // late ack in FETCH
        step();                                   // WAIT 0x100
        icache_ack = 1'b0;
        check("wr_late_dv",   {31'd0, de_valid},   32'd0);
        check("wr_late_req",  {31'd0, icache_req}, 32'd1);
        check("wr_late_addr", icache_addr,         32'h0000_0100);
        step();                                   // still waiting
        check("wr_wait_dv",  {31'd0, de_valid},   32'd0);
        check("wr_wait_req", {31'd0, icache_req}, 32'd1);
        icache_ack = 1'b1; icache_rdata = 32'hA000_0100;
        step();
        icache_ack = 1'b0;
        check("wr_final_dv",    {31'd0, de_valid}, 32'd1);
        check("wr_final_pc",    de_pc,             32'h0000_0100);
        check("wr_final_instr", de_instr,          32'hA000_0100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
